// File: rtl/bcd_cascade_counter.sv
// bcd_cascade_counter: synchronous N-digit BCD counter with programmable top-digit modulus; define UPDOWN_EN to add the dn input for down counting
module bcd_cascade_counter #(
    parameter int DIGITS  = 2,
    parameter int TOP_MOD = 10,
    parameter int DELAY   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
`ifdef UPDOWN_EN
    input  logic                dn,
`endif
    input  logic                clr,
    input  logic                set9,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic                ovf
);
    if (DIGITS < 1 || DIGITS > 8 || TOP_MOD < 2 || TOP_MOD > 10 || DELAY < 0) begin : g_bad_param
        $error("bcd_cascade_counter: parameter out of range");
    end
    logic [DIGITS:0]       cy;
    logic [4*DIGITS-1:0]   q_up, q_step, set_val;
    logic                  wrap;
    assign cy[0] = 1'b1;
`ifdef UPDOWN_EN
    logic [DIGITS:0]       bw;
    logic [4*DIGITS-1:0]   q_dn;
    assign bw[0] = 1'b1;
`endif
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam logic [3:0] MX = (i == DIGITS - 1) ? 4'(TOP_MOD - 1) : 4'd9;
        logic [3:0] d;
        assign d = q[4*i+:4];
        assign cy[i+1] = cy[i] & (d >= MX);
        assign q_up[4*i+:4] = !cy[i] ? d : (d >= MX) ? 4'd0 : d + 4'd1;
        assign set_val[4*i+:4] = MX;
`ifdef UPDOWN_EN
        assign bw[i+1] = bw[i] & (d == 4'd0);
        assign q_dn[4*i+:4] = !bw[i] ? d : (d == 4'd0) ? MX : d - 4'd1;
`endif
    end
`ifdef UPDOWN_EN
    assign q_step = dn ? q_dn : q_up;
    assign wrap   = dn ? bw[DIGITS] : cy[DIGITS];
`else
    assign q_step = q_up;
    assign wrap   = cy[DIGITS];
`endif
    assign tc = en & wrap;
    // counter state and sticky wrap flag, priority clr > set9 > load > en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (set9) begin
            q   <= set_val;
            ovf <= 1'b0;
        end else if (load) begin
            q   <= load_val;
            ovf <= 1'b0;
        end else if (en) begin
            q <= q_step;
            if (wrap) ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bcd_cascade_counter.sv
// tb_bcd_cascade_counter: checks a 2-digit mod-60 and a 4-digit mod-2000 counter against a digit-list model
module tb_bcd_cascade_counter;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, dn = 1'b0, clr = 1'b0, set9 = 1'b0, load = 1'b0;
    logic [7:0]  lv0 = '0, q0;
    logic [15:0] lv1 = '0, q1;
    logic tc0, tc1, ovf0, ovf1;
    logic [31:0] m0 = '0, m1 = '0;
    bit o0 = 1'b0, o1 = 1'b0;
    int total = 0, bad = 0;

    typedef struct {
        bit c, s, l, e;
        logic [7:0] lv;
        bit tc;
        logic [7:0] q;
        bit ovf;
    } vec_t;
    vec_t tbl[$];

    bcd_cascade_counter #(.DIGITS(2), .TOP_MOD(6)) u0 (
        .clk(clk), .rst(rst), .en(en),
`ifdef UPDOWN_EN
        .dn(dn),
`endif
        .clr(clr), .set9(set9), .load(load), .load_val(lv0), .q(q0), .tc(tc0), .ovf(ovf0));
    bcd_cascade_counter #(.DIGITS(4), .TOP_MOD(2)) u1 (
        .clk(clk), .rst(rst), .en(en),
`ifdef UPDOWN_EN
        .dn(dn),
`endif
        .clr(clr), .set9(set9), .load(load), .load_val(lv1), .q(q1), .tc(tc1), .ovf(ovf1));

    always #5 clk = ~clk;

    function automatic int mx(input int i, input int nd, input int tm);
        return (i == nd - 1) ? tm - 1 : 9;
    endfunction

    function automatic logic [31:0] stepv(input logic [31:0] v, input int nd, input int tm, input bit down, output bit w);
        logic [31:0] r = v;
        int d;
        w = 1'b1;
        for (int i = 0; i < nd; i++) begin
            d = int'(r[4*i+:4]);
            if (!down) begin
                if (d >= mx(i, nd, tm)) r[4*i+:4] = 4'd0;
                else begin r[4*i+:4] = 4'(d + 1); w = 1'b0; break; end
            end else begin
                if (d == 0) r[4*i+:4] = 4'(mx(i, nd, tm));
                else begin r[4*i+:4] = 4'(d - 1); w = 1'b0; break; end
            end
        end
        return r;
    endfunction

    function automatic bit atend(input logic [31:0] v, input int nd, input int tm, input bit down);
        bit a = 1'b1;
        for (int i = 0; i < nd; i++)
            if (down ? (v[4*i+:4] != 4'd0) : (int'(v[4*i+:4]) < mx(i, nd, tm))) a = 1'b0;
        return a;
    endfunction

    function automatic logic [31:0] maxv(input int nd, input int tm);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++) r[4*i+:4] = 4'(mx(i, nd, tm));
        return r;
    endfunction

    function automatic logic [31:0] bcd2(input int k);
        return 32'((k / 10) * 16 + k % 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        bit w;
        #1;
        chk("tc0", 32'(tc0), 32'(en & atend(m0, 2, 6, dn)));
        chk("tc1", 32'(tc1), 32'(en & atend(m1, 4, 2, dn)));
        @(posedge clk);
        if (clr) begin
            m0 = '0; m1 = '0; o0 = 1'b0; o1 = 1'b0;
        end else if (set9) begin
            m0 = maxv(2, 6); m1 = maxv(4, 2); o0 = 1'b0; o1 = 1'b0;
        end else if (load) begin
            m0 = 32'(lv0); m1 = 32'(lv1); o0 = 1'b0; o1 = 1'b0;
        end else if (en) begin
            m0 = stepv(m0, 2, 6, dn, w); if (w) o0 = 1'b1;
            m1 = stepv(m1, 4, 2, dn, w); if (w) o1 = 1'b1;
        end
        #1;
        chk("q0", 32'(q0), m0);
        chk("ovf0", 32'(ovf0), 32'(o0));
        chk("q1", 32'(q1), m1);
        chk("ovf1", 32'(ovf1), 32'(o1));
        @(negedge clk);
    endtask

    task automatic setin(input bit c, input bit s, input bit l, input bit e, input logic [7:0] v);
        clr = c; set9 = s; load = l; en = e; lv0 = v; lv1 = {v, v};
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_q0", 32'(q0), 0);
        chk("rst_ovf0", 32'(ovf0), 0);
        chk("rst_q1", 32'(q1), 0);
        chk("rst_ovf1", 32'(ovf1), 0);
        m0 = '0; m1 = '0; o0 = 1'b0; o1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl.push_back(vec_t'{0, 0, 1, 0, 8'h37, 0, 8'h37, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 8'h00, 0, 8'h38, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 8'h00, 0, 8'h39, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 8'h00, 0, 8'h40, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0, 8'h00, 0, 8'h59, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 8'h00, 1, 8'h00, 1});
        tbl.push_back(vec_t'{0, 1, 0, 1, 8'h00, 0, 8'h59, 0});
        tbl.push_back(vec_t'{1, 0, 1, 1, 8'h45, 1, 8'h00, 0});
        tbl.push_back(vec_t'{0, 0, 1, 0, 8'hFF, 0, 8'hFF, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 8'h00, 1, 8'h00, 1});
        tbl.push_back(vec_t'{0, 0, 0, 0, 8'h00, 0, 8'h00, 1});
        tbl.push_back(vec_t'{0, 0, 1, 1, 8'h23, 0, 8'h23, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 8'h00, 0, 8'h24, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0, 8'h11, 0, 8'h59, 0});
        tbl.push_back(vec_t'{0, 0, 1, 0, 8'h5A, 0, 8'h5A, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 8'h00, 1, 8'h00, 1});
        tbl.push_back(vec_t'{0, 0, 1, 0, 8'h3F, 0, 8'h3F, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 8'h00, 0, 8'h40, 0});

        repeat (2) @(negedge clk);
        #1;
        chk("reset_q0", 32'(q0), 0);
        chk("reset_ovf0", 32'(ovf0), 0);
        chk("reset_tc0", 32'(tc0), 0);
        chk("reset_q1", 32'(q1), 0);
        rst = 1'b0;

        en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            #1;
            chk("cnt_tc", 32'(tc0), 32'(k == 59));
            tick();
            chk("cnt_q", 32'(q0), bcd2((k + 1) % 60));
            chk("cnt_ovf", 32'(ovf0), 32'(k == 59));
        end

        foreach (tbl[n]) begin
            setin(tbl[n].c, tbl[n].s, tbl[n].l, tbl[n].e, tbl[n].lv);
            #1;
            chk($sformatf("tbl%0d_tc", n), 32'(tc0), 32'(tbl[n].tc));
            tick();
            chk($sformatf("tbl%0d_q", n), 32'(q0), 32'(tbl[n].q));
            chk($sformatf("tbl%0d_ovf", n), 32'(ovf0), 32'(tbl[n].ovf));
        end

        setin(0, 1, 0, 0, 8'h00);
        tick();
        setin(0, 0, 0, 1, 8'h00);
        repeat (24) tick();
        chk("pre_rst_q", 32'(q0), 32'h23);
        chk("pre_rst_ovf", 32'(ovf0), 1);
        do_reset();
        tick();
        chk("post_rst_q", 32'(q0), 32'h01);

`ifdef UPDOWN_EN
        do_reset();
        dn = 1'b1;
        #1;
        chk("dn_tc", 32'(tc0), 1);
        tick();
        chk("dn_q0", 32'(q0), 32'h59);
        chk("dn_ovf0", 32'(ovf0), 1);
        chk("dn_q1", 32'(q1), 32'h1999);
        dn = 1'b0;
`endif

        setin(0, 0, 1, 0, 8'h00);
        lv1 = 16'h1999;
        tick();
        setin(0, 0, 0, 1, 8'h00);
        #1;
        chk("u1_tc", 32'(tc1), 1);
        tick();
        chk("u1_wrap_q", 32'(q1), 0);
        chk("u1_wrap_ovf", 32'(ovf1), 1);

        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            clr = (r < 4);
            set9 = (r >= 4 && r < 8);
            load = (r >= 8 && r < 16);
            en = ($urandom % 4) != 0;
            lv0 = 8'($urandom);
            lv1 = 16'($urandom);
`ifdef UPDOWN_EN
            dn = 1'($urandom);
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
